// File: rtl/seg_pkg.sv
// Shared constants for the 7-segment scan controller: blank pattern, anode
// polarity, the hex segment table and width helpers.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic       AN_ON     = 1'b0;
    localparam logic       AN_OFF    = 1'b1;

    // Active-low {a,b,c,d,e,f,g}; element [n] is the pattern for hex digit n.
    localparam logic [15:0][6:0] HEX_SEG_TABLE = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

    function automatic int clog2(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Register width for a counter over n states; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_hex_dec.sv
// Combinational hex nibble to active-low 7-segment decoder.
module seg_hex_dec
    import seg_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = HEX_SEG_TABLE[nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scan controller with a dead-time
// blank per slot and frame-synchronous double-buffered display value.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int DEAD     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     en_mask,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  frame_tick
);

    localparam int CNT_W = idx_width(PRESCALE);
    localparam int IDX_W = idx_width(DIGITS);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] pending_q, pending_d;
    logic [4*DIGITS-1:0] active_q, active_d;
    logic                pend_valid_q, pend_valid_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                wrap_q, wrap_d;
    logic                frame_tick_q, frame_tick_d;

    logic                last_cnt_s;
    logic                last_idx_s;
    logic                boundary_s;
    logic [3:0]          nib_s;
    logic [6:0]          dec_seg_s;
    logic [DIGITS-1:0]   lzb_blank_s;

    // Single shared decoder fed with the nibble of the slot being scanned.
    assign nib_s = 4'(active_q >> {idx_q, 2'b00});

    seg_hex_dec u_dec (
        .nib (nib_s),
        .seg (dec_seg_s)
    );

`ifdef SEG_LZB_EN
    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        logic zero_run;
        zero_run    = 1'b1;
        lzb_blank_s = '0;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            zero_run       = zero_run & (active_q[4*k +: 4] == 4'h0);
            lzb_blank_s[k] = zero_run;
        end
    end
`else
    // Without blanking every enabled digit shows its nibble.
    always_comb begin
        lzb_blank_s = '0;
    end
`endif

    // Prescaler, slot index and the frame-boundary buffer transfer.
    always_comb begin
        last_cnt_s   = (cnt_q == CNT_W'(PRESCALE - 1));
        last_idx_s   = (idx_q == IDX_W'(DIGITS - 1));
        boundary_s   = last_cnt_s && last_idx_s;
        pending_d    = pending_q;
        pend_valid_d = pend_valid_q;
        active_d     = active_q;

        if (last_cnt_s) begin
            cnt_d = '0;
            idx_d = last_idx_s ? '0 : idx_q + IDX_W'(1);
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
            idx_d = idx_q;
        end

        // A load on the boundary itself goes straight to the active buffer.
        if (boundary_s) begin
            active_d     = load ? value : (pend_valid_q ? pending_q : active_q);
            pend_valid_d = 1'b0;
        end else if (load) begin
            pending_d    = value;
            pend_valid_d = 1'b1;
        end else begin
            pending_d    = pending_q;
            pend_valid_d = pend_valid_q;
        end
    end

    // Next-cycle anode/segment drive; frame_tick lags one extra stage so it
    // lines up with the registered outputs of slot 0's first blank cycle.
    always_comb begin
        an_d         = {DIGITS{AN_OFF}};
        seg_d        = SEG_BLANK;
        wrap_d       = boundary_s;
        frame_tick_d = wrap_q;
        if (cnt_q >= CNT_W'(DEAD)) begin
            an_d[idx_q] = en_mask[idx_q] ? AN_ON : AN_OFF;
            seg_d       = lzb_blank_s[idx_q] ? SEG_BLANK : dec_seg_s;
        end else begin
            an_d  = {DIGITS{AN_OFF}};
            seg_d = SEG_BLANK;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pending_q    <= '0;
            active_q     <= '0;
            pend_valid_q <= 1'b0;
            an_q         <= {DIGITS{AN_OFF}};
            seg_q        <= SEG_BLANK;
            wrap_q       <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            active_q     <= active_d;
            pend_valid_q <= pend_valid_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            wrap_q       <= wrap_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: per-cycle reference model, vector
// table of frame contents, hand sequences for buffering and reset corners.
module tb_seg_scan_ctrl;

    localparam int DIGITS   = 4;
    localparam int PRESCALE = 8;
    localparam int DEAD     = 2;
    localparam int FRAME    = DIGITS * PRESCALE;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  en_mask = 4'hF;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_tick;

    seg_scan_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE), .DEAD(DEAD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .en_mask    (en_mask),
        .an         (an),
        .seg        (seg),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        string           name;
        logic [15:0]     value;
        logic [3:0]      mask;
        logic [3:0][6:0] seg_exp;
    } vec_t;

    int          n_checks = 0;
    int          n_err = 0;
    int          c = 0;
    logic [15:0] m_active = 16'h0;
    logic [15:0] m_pending = 16'h0;
    logic        m_pv = 1'b0;
    logic [6:0]  hex_ref [16];
    vec_t        tbl [8];
    vec_t        tv;
    logic        tv_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, c);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [15:0] v, input logic [3:0] m,
                                input logic [3:0][6:0] s);
        vec_t e;
        e.name = name; e.value = v; e.mask = m; e.seg_exp = s;
        return e;
    endfunction

    function automatic logic [6:0] ref_seg(input int ph, input int idx, input logic [15:0] act);
        int nib;
        if (ph < DEAD) return 7'h7F;
`ifdef SEG_LZB_EN
        if (idx > 0 && (act >> (4 * idx)) == 16'h0) return 7'h7F;
`endif
        nib = int'((act >> (4 * idx)) & 16'hF);
        return hex_ref[nib];
    endfunction

    task automatic model_reset();
        c = 0; m_active = 16'h0; m_pending = 16'h0; m_pv = 1'b0;
    endtask

    // One clock: drive inputs, predict the outputs of the coming edge, advance.
    task automatic step(input logic ld, input logic [15:0] v, input logic [3:0] m);
        int ph, idx;
        logic [3:0] e_an, t_an;
        logic [6:0] e_seg;
        logic       e_ft;
        load = ld; value = v; en_mask = m;
        ph   = c % PRESCALE;
        idx  = (c / PRESCALE) % DIGITS;
        e_an = 4'hF;
        if (ph >= DEAD && m[idx]) e_an[idx] = 1'b0;
        e_seg = ref_seg(ph, idx, m_active);
        e_ft  = ((c + 1) % FRAME == 1) && (c + 1 > FRAME);
        if (c % FRAME == FRAME - 1) begin
            m_active = ld ? v : (m_pv ? m_pending : m_active);
            m_pv = 1'b0;
        end else if (ld) begin
            m_pending = v;
            m_pv = 1'b1;
        end
        @(posedge clk);
        #1;
        c++;
        chk("an", 32'(an), 32'(e_an));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("frame_tick", 32'(frame_tick), 32'(e_ft));
        if (tv_on && ph == 4) begin
            t_an = 4'hF;
            if (tv.mask[idx]) t_an[idx] = 1'b0;
            chk({"tbl_seg_", tv.name}, 32'(seg), 32'(tv.seg_exp[idx]));
            chk({"tbl_an_", tv.name}, 32'(an), 32'(t_an));
        end
        load = 1'b0;
    endtask

    task automatic run_to(input int phase, input logic [3:0] m);
        while (c % FRAME != phase) step(1'b0, 16'h0, m);
    endtask

    task automatic show_frame(input vec_t e);
        tv = e; tv_on = 1'b1;
        repeat (FRAME) step(1'b0, 16'h0, e.mask);
        tv_on = 1'b0;
    endtask

    initial begin
        hex_ref = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
`ifdef SEG_LZB_EN
        tbl[0] = mk("zero", 16'h0000, 4'hF, {7'h7F, 7'h7F, 7'h7F, 7'b0000001});
        tbl[5] = mk("0040", 16'h0040, 4'hF, {7'h7F, 7'h7F, 7'b1001100, 7'b0000001});
`else
        tbl[0] = mk("zero", 16'h0000, 4'hF, {4{7'b0000001}});
        tbl[5] = mk("0040", 16'h0040, 4'hF, {7'b0000001, 7'b0000001, 7'b1001100, 7'b0000001});
`endif
        tbl[1] = mk("12AF", 16'h12AF, 4'hF, {7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000});
        tbl[2] = mk("8888m5", 16'h8888, 4'b0101, {4{7'b0000000}});
        tbl[3] = mk("4567mA", 16'h4567, 4'b1010, {7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111});
        tbl[4] = mk("9BCD", 16'h9BCD, 4'hF, {7'b0000100, 7'b1100000, 7'b0110001, 7'b1000010});
        tbl[6] = mk("2222", 16'h2222, 4'hF, {4{7'b0010010}});
        tbl[7] = mk("3333", 16'h3333, 4'hF, {4{7'b0000110}});

        // Reset state.
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_an", 32'(an), 32'h0000000F);
        chk("rst_seg", 32'(seg), 32'h0000007F);
        chk("rst_ft", 32'(frame_tick), 32'h0);
        rst_n = 1'b1;

        // Plain scan of zero over two frames.
        show_frame(tbl[0]);
        show_frame(tbl[0]);

        // Table: load mid-slot 1, display only after the next boundary.
        for (int i = 0; i < 6; i++) begin
            run_to(10, tbl[i].mask);
            step(1'b1, tbl[i].value, tbl[i].mask);
            run_to(0, tbl[i].mask);
            show_frame(tbl[i]);
        end

        // Two loads in one frame, last wins; then a load on the boundary cycle.
        run_to(5, 4'hF);
        step(1'b1, 16'h1111, 4'hF);
        run_to(20, 4'hF);
        step(1'b1, 16'h2222, 4'hF);
        run_to(0, 4'hF);
        tv = tbl[6]; tv_on = 1'b1;
        repeat (FRAME - 1) step(1'b0, 16'h0, 4'hF);
        step(1'b1, 16'h3333, 4'hF);
        tv_on = 1'b0;
        show_frame(tbl[7]);

        // Asynchronous reset during slot 2 drive phase.
        run_to(20, 4'hF);
        rst_n = 1'b0;
        #1;
        chk("async_an", 32'(an), 32'h0000000F);
        chk("async_seg", 32'(seg), 32'h0000007F);
        chk("async_ft", 32'(frame_tick), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        chk("hold_an", 32'(an), 32'h0000000F);
        rst_n = 1'b1;
        show_frame(tbl[0]);

        // Randomized loads, values and masks against the model.
        for (int i = 0; i < 800; i++) begin
            step(($urandom_range(0, 7) == 0), 16'($urandom), 4'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
